mdu_ctrl: RTL and testbench

- Sequences the multi-cycle multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Accepts one operation from EXE and runs a counted multiply wait or a 32-step restoring divide.
- Writes HI/LO once, as a single one-cycle pulse.
- Holds `stall` high while busy, so the ID-side hazard logic freezes the front of the pipe.

---
 rtl/mdu_ctrl_pkg.sv | 25 ++
 rtl/mdu_ctrl_div_restoring.sv | 25 ++
 rtl/mdu_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mdu_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings and control constants for the multiply/divide sequencer.
package mdu_ctrl_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MUL_WAIT = 3'd1,
      DIV_RUN  = 3'd2,
      DIV_FIX  = 3'd3,
      WRITE    = 3'd4
   } mdu_state_e;

   localparam logic RST_ENABLED    = 1'b1;
   localparam logic WRITE_ENABLED  = 1'b1;
   localparam logic WRITE_DISABLED = 1'b0;
   localparam logic STOP           = 1'b1;
   localparam logic RUN            = 1'b0;

endpackage

// File: rtl/mdu_ctrl_div_restoring.sv
// One combinational restoring-divide step: shift in a dividend bit, trial subtract.
module div_restoring
   import mdu_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             quo_bit
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH:0]   diff;

   // Trial subtraction; keep the shifted remainder when the divisor does not fit.
   always_comb begin
      shifted = {rem_in, dividend_bit};
      quo_bit = (shifted >= {2'b00, divisor});
      diff    = shifted[WIDTH:0] - {1'b0, divisor};
      rem_out = quo_bit ? diff : shifted[WIDTH:0];
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with a single HI/LO write pulse.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [1:0]       req_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             stall,
   output logic             hi_wena,
   output logic             lo_wena,
   output logic [WIDTH-1:0] hi_wdata,
   output logic [WIDTH-1:0] lo_wdata
);

   localparam int unsigned CNT_W = ($clog2(MUL_LAT) > $clog2(WIDTH)) ?
                                   $clog2(MUL_LAT) : $clog2(WIDTH);

   mdu_state_e       state;
   mdu_op_e          op_q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] dvd_q;      // dividend magnitude, becomes quotient as bits shift in
   logic [WIDTH-1:0] dvs_q;      // divisor magnitude
   logic [WIDTH:0]   rem_q;      // partial remainder
   logic             quo_neg_q;
   logic             rem_neg_q;
   logic             div_zero_q;

   mdu_op_e            req_op_e;
   logic [2*WIDTH-1:0] mul_a;
   logic [2*WIDTH-1:0] mul_b;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     step_rem;
   logic               step_quo;
   logic [WIDTH-1:0]   fix_quo;
   logic [WIDTH-1:0]   fix_rem;

   assign req_op_e = mdu_op_e'(req_op);

   // Full-width product of the latched operands, sign- or zero-extended by op.
   always_comb begin
      if (op_q == MDU_MULT) begin
         mul_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
         mul_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
      end else begin
         mul_a = {{WIDTH{1'b0}}, a_q};
         mul_b = {{WIDTH{1'b0}}, b_q};
      end
      prod = mul_a * mul_b;
   end

   div_restoring #(.WIDTH(WIDTH)) u_step (
      .rem_in       (rem_q),
      .dividend_bit (dvd_q[WIDTH-1]),
      .divisor      (dvs_q),
      .rem_out      (step_rem),
      .quo_bit      (step_quo)
   );

   // Sign correction of the magnitude result; divide-by-zero returns fixed values.
   always_comb begin
      fix_quo = quo_neg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
      fix_rem = rem_neg_q ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
      if (div_zero_q) begin
         fix_quo = '1;
         fix_rem = a_q;
      end
   end

   // Sequencer: state, counter, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLED) begin
         state      <= IDLE;
         op_q       <= MDU_MULT;
         cnt        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         rem_q      <= '0;
         quo_neg_q  <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         stall      <= RUN;
         hi_wena    <= WRITE_DISABLED;
         lo_wena    <= WRITE_DISABLED;
         hi_wdata   <= '0;
         lo_wdata   <= '0;
      end else begin
         hi_wena <= WRITE_DISABLED;
         lo_wena <= WRITE_DISABLED;
         case (state)
            IDLE: begin
               if (req && !flush) begin
                  op_q       <= req_op_e;
                  a_q        <= src_a;
                  b_q        <= src_b;
                  rem_q      <= '0;
                  div_zero_q <= (src_b == '0);
                  stall      <= STOP;
                  if (req_op_e == MDU_DIV) begin
                     dvd_q     <= src_a[WIDTH-1] ? (~src_a + WIDTH'(1)) : src_a;
                     dvs_q     <= src_b[WIDTH-1] ? (~src_b + WIDTH'(1)) : src_b;
                     quo_neg_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                     rem_neg_q <= src_a[WIDTH-1];
                  end else begin
                     dvd_q     <= src_a;
                     dvs_q     <= src_b;
                     quo_neg_q <= 1'b0;
                     rem_neg_q <= 1'b0;
                  end
                  if (req_op[1]) begin
                     state <= DIV_RUN;
                     cnt   <= CNT_W'(WIDTH - 1);
                  end else begin
                     state <= MUL_WAIT;
                     cnt   <= CNT_W'(MUL_LAT - 2);
                  end
               end
            end
            MUL_WAIT: begin
               if (flush) begin
                  state <= IDLE;
                  stall <= RUN;
               end else if (cnt == '0) begin
                  state    <= WRITE;
                  hi_wena  <= WRITE_ENABLED;
                  lo_wena  <= WRITE_ENABLED;
                  hi_wdata <= prod[2*WIDTH-1:WIDTH];
                  lo_wdata <= prod[WIDTH-1:0];
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DIV_RUN: begin
               if (flush) begin
                  state <= IDLE;
                  stall <= RUN;
               end else begin
                  rem_q <= step_rem;
                  dvd_q <= {dvd_q[WIDTH-2:0], step_quo};
                  if (cnt == '0) begin
                     state <= DIV_FIX;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
            end
            DIV_FIX: begin
               if (flush) begin
                  state <= IDLE;
                  stall <= RUN;
               end else begin
                  state    <= WRITE;
                  hi_wena  <= WRITE_ENABLED;
                  lo_wena  <= WRITE_ENABLED;
                  hi_wdata <= fix_rem;
                  lo_wdata <= fix_quo;
               end
            end
            default: begin
               state <= IDLE;
               stall <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus random ops vs a reference model.
module tb_mdu_ctrl;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned MUL_LAT = 4;
   localparam int unsigned DIV_LAT = 34;

   logic             clk = 1'b0;
   logic             rst;
   logic             req;
   logic [1:0]       req_op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             stall;
   logic             hi_wena;
   logic             lo_wena;
   logic [WIDTH-1:0] hi_wdata;
   logic [WIDTH-1:0] lo_wdata;

   int n_assert = 0;
   int n_fail   = 0;
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   mdu_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_op   (req_op),
      .src_a    (src_a),
      .src_b    (src_b),
      .flush    (flush),
      .stall    (stall),
      .hi_wena  (hi_wena),
      .lo_wena  (lo_wena),
      .hi_wdata (hi_wdata),
      .lo_wdata (lo_wdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural result of one operation, from plain 64-bit arithmetic.
   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l);
      longint          sa, sb, p;
      longint unsigned up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
         2'b01: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
         2'b10: begin
            if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
            else begin p = sa / sb; l = p[31:0]; p = sa % sb; h = p[31:0]; end
         end
         default: begin
            if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
            else begin l = a / b; h = a % b; end
         end
      endcase
   endtask

   // Issue one op in the current cycle and check every cycle up to and after the write.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
      int lat;
      lat    = op[1] ? DIV_LAT : MUL_LAT;
      req    = 1'b1;
      req_op = op;
      src_a  = a;
      src_b  = b;
      for (int k = 1; k <= lat; k++) begin
         tick();
         req    = 1'b0;
         req_op = 2'($urandom_range(0, 3));
         src_a  = $urandom;
         src_b  = $urandom;
         chk("stall_busy", 64'(stall), 64'(1));
         if (k < lat) begin
            chk("wena_early", 64'({hi_wena, lo_wena}), 64'(0));
            chk("hold_busy", {hi_wdata, lo_wdata}, {last_hi, last_lo});
         end else begin
            chk("wena_write", 64'({hi_wena, lo_wena}), 64'(3));
            chk("hi_result", 64'(hi_wdata), 64'(eh));
            chk("lo_result", 64'(lo_wdata), 64'(el));
         end
      end
      last_hi = eh;
      last_lo = el;
      tick();
      chk("stall_after", 64'(stall), 64'(0));
      chk("wena_after", 64'({hi_wena, lo_wena}), 64'(0));
      chk("hold_after", {hi_wdata, lo_wdata}, {last_hi, last_lo});
   endtask

   task automatic run_rand(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh, el;
      model(op, a, b, eh, el);
      run_op(op, a, b, eh, el);
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      rst = 1'b1; req = 1'b0; req_op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;

      // reset state
      tick(); tick();
      chk("reset_outs", {27'b0, stall, hi_wena, lo_wena, 2'b0, hi_wdata}, 64'(0));
      chk("reset_lo", 64'(lo_wdata), 64'(0));
      rst = 1'b0;
      tick();
      chk("idle_stall", 64'(stall), 64'(0));

      // directed cases with hand-derived results
      run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op(2'b01, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
      run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // flush mid-divide at T+10, then a fresh request at T+11
      req = 1'b1; req_op = 2'b10; src_a = 32'd1000; src_b = 32'd7;
      for (int k = 1; k <= 10; k++) begin
         tick();
         req = 1'b0;
         chk("flush_pre_stall", 64'(stall), 64'(1));
         chk("flush_pre_wena", 64'({hi_wena, lo_wena}), 64'(0));
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_stall", 64'(stall), 64'(0));
      chk("flush_wena", 64'({hi_wena, lo_wena}), 64'(0));
      chk("flush_hold", {hi_wdata, lo_wdata}, {last_hi, last_lo});
      run_rand(2'b11, 32'd1000, 32'd7);

      // synchronous reset in the middle of a divide
      req = 1'b1; req_op = 2'b10; src_a = 32'hDEAD_BEEF; src_b = 32'd13;
      for (int k = 1; k <= 5; k++) begin
         tick();
         req = 1'b0;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_ctrl", 64'({stall, hi_wena, lo_wena}), 64'(0));
      chk("rst_mid_data", {hi_wdata, lo_wdata}, 64'(0));
      last_hi = '0;
      last_lo = '0;
      for (int k = 0; k < 40; k++) begin
         tick();
         chk("rst_no_write", 64'({stall, hi_wena, lo_wena}), 64'(0));
      end

      // req together with flush in IDLE is dropped
      req = 1'b1; flush = 1'b1; req_op = 2'b00; src_a = 32'd5; src_b = 32'd6;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("reqflush_idle", 64'({stall, hi_wena, lo_wena}), 64'(0));
      end
      req = 1'b0; flush = 1'b0;
      tick();

      // random operations against the reference model
      for (int i = 0; i < 24; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
         case ($urandom_range(0, 5))
            0:       b = 32'h0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 15));
            default: b = 32'($urandom);
         endcase
         run_rand(op, a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
